fns_decoder_seq: RTL and testbench



---
 rtl/fns_decoder_seq_pkg.sv | 25 ++
 rtl/fns_decoder_seq_weight_mux.sv | 30 +++
 rtl/fns_decoder_seq.sv | 136 +++++++++++++
 tb/tb_fns_decoder_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fns_decoder_seq_pkg.sv
// Shared definitions for the bit-serial FNS/CAC decoder: FSM encoding,
// fns_vec weight slicing helper and the reference weight sets.
package fns_decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widest packed weight vector the slicing helper can handle.
  localparam int FNS_VEC_MAX = 64;

  // Weight sets for a 4-TSV group, bit 3 down to bit 0, 3-bit weights.
  localparam logic [11:0] FNS_W_DEFAULT  = {3'd3, 3'd2, 3'd1, 3'd1};
  localparam logic [11:0] FNS_W_OVERFLOW = {3'd5, 3'd3, 3'd2, 3'd1};

  function automatic logic [31:0] fnsWeight(input logic [FNS_VEC_MAX-1:0] vec,
                                            input int idx, input int wLen);
    logic [FNS_VEC_MAX-1:0] mask;
    mask = (FNS_VEC_MAX'(1) << wLen) - FNS_VEC_MAX'(1);
    return 32'((vec >> (idx * wLen)) & mask);
  endfunction

endpackage

// File: rtl/fns_decoder_seq_weight_mux.sv
// Combinational select of the weight for the codeword bit currently being
// accumulated; a cleared or disabled bit contributes zero.
module fns_weight_mux
  import fns_decoder_seq_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter int W_LEN  = 3,
  parameter int IDX_W  = 2
) (
  input  logic [N_BITS-1:0]        i_code,
  input  logic [N_BITS-1:0]        i_en,
  input  logic [N_BITS*W_LEN-1:0]  i_fnsVec,
  input  logic [IDX_W-1:0]         i_idx,
  output logic [W_LEN-1:0]         o_weight
);

  logic [FNS_VEC_MAX-1:0] w_vecWide;

  assign w_vecWide = FNS_VEC_MAX'(i_fnsVec);

  always_comb begin
    o_weight = '0;
    for (int i = 0; i < N_BITS; i++) begin
      if ((i_idx == IDX_W'(i)) && i_code[i] && i_en[i]) begin
        o_weight = W_LEN'(fnsWeight(w_vecWide, i, W_LEN));
      end
    end
  end

endmodule

// File: rtl/fns_decoder_seq.sv
// Bit-serial FNS codeword decoder, MSB first, valid/ready on both sides.
// Optional range check enabled by defining FNS_DEC_RANGE_CHK_EN.
module fns_decoder_seq
  import fns_decoder_seq_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter int W_LEN  = 3,
  parameter int DATA_W = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_BITS-1:0]        codein,
  input  logic [N_BITS-1:0]        en_flag,
  input  logic [N_BITS*W_LEN-1:0]  fns_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        dataout,
  output logic                     dec_err
);

  localparam int ACC_W = W_LEN + $clog2(N_BITS) + 1;
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  if (ACC_W < DATA_W) begin : g_accWidthCheck
    $error("fns_decoder_seq: ACC_W must be >= DATA_W");
  end

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [IDX_W-1:0]        r_idx;
  logic [ACC_W-1:0]        r_acc;
  logic [ACC_W-1:0]        w_accNext;
  logic [N_BITS-1:0]       r_code;
  logic [N_BITS-1:0]       r_en;
  logic [N_BITS*W_LEN-1:0] r_fns;
  logic                    r_inReady;
  logic                    r_outValid;
  logic [DATA_W-1:0]       r_dataout;
  logic [W_LEN-1:0]        w_weight;
  logic                    w_accept;

  assign w_accept = (r_state == IDLE) && r_inReady && in_valid;

  fns_weight_mux #(
    .N_BITS (N_BITS),
    .W_LEN  (W_LEN),
    .IDX_W  (IDX_W)
  ) u_weightMux (
    .i_code   (r_code),
    .i_en     (r_en),
    .i_fnsVec (r_fns),
    .i_idx    (r_idx),
    .o_weight (w_weight)
  );

  assign w_accNext = r_acc + ACC_W'(w_weight);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_stateNext = ACCUM;
      ACCUM:   if (r_idx == '0) w_stateNext = DONE;
      DONE:    if (out_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // in_ready is registered so it reads 0 for as long as reset is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_dataout  <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_code     <= '0;
      r_en       <= '0;
      r_fns      <= '0;
    end else begin
      r_inReady <= (w_stateNext == IDLE);
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_code <= codein;
            r_en   <= en_flag;
            r_fns  <= fns_vec;
            r_acc  <= '0;
            r_idx  <= IDX_W'(N_BITS - 1);
          end
        end
        ACCUM: begin
          r_acc <= w_accNext;
          if (r_idx == '0) begin
            r_outValid <= 1'b1;
            r_dataout  <= w_accNext[DATA_W-1:0];
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FNS_DEC_RANGE_CHK_EN
  logic r_decErr;

  // Flags any accumulated weight that does not fit in DATA_W bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_decErr <= 1'b0;
    end else if ((r_state == ACCUM) && (r_idx == '0)) begin
      r_decErr <= ((w_accNext >> DATA_W) != '0);
    end
  end

  assign dec_err = r_decErr;
`else
  assign dec_err = 1'b0;
`endif

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign dataout   = r_dataout;

endmodule

// File: tb/tb_fns_decoder_seq.sv
// Self-checking bench for fns_decoder_seq: directed vector table, hand-written
// reset sequences and randomized words against an arithmetic reference model.
module tb_fns_decoder_seq;

  localparam int N_BITS = 4;
  localparam int W_LEN  = 3;
  localparam int DATA_W = 3;
`ifdef FNS_DEC_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [11:0] W_STD  = {3'd3, 3'd2, 3'd1, 3'd1};
  localparam logic [11:0] W_OVER = {3'd5, 3'd3, 3'd2, 3'd1};

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  codein;
  logic [3:0]  en_flag;
  logic [11:0] fns_vec;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  dataout;
  logic        dec_err;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [3:0]  en;
    logic [11:0] fns;
    bit          scramble;
    bit          earlyReady;
    int          holdCycles;
    int          expData;
    int          expErrRaw;
  } vec_t;

  vec_t table_q[$];

  fns_decoder_seq #(
    .N_BITS (N_BITS),
    .W_LEN  (W_LEN),
    .DATA_W (DATA_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codein    (codein),
    .en_flag   (en_flag),
    .fns_vec   (fns_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .dec_err   (dec_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: plain weighted sum of the usable, set bits.
  function automatic int refSum(input logic [3:0] code, input logic [3:0] en,
                                input logic [11:0] fns);
    int weights[4];
    int sum = 0;
    weights[0] = int'(fns[2:0]);
    weights[1] = int'(fns[5:3]);
    weights[2] = int'(fns[8:6]);
    weights[3] = int'(fns[11:9]);
    for (int i = 0; i < 4; i++) begin
      if (code[i] === 1'b1 && en[i] === 1'b1) sum += weights[i];
    end
    return sum;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int waitCnt = 0;
    int lat = 0;
    int expErr = RANGE_CHK ? v.expErrRaw : 0;
    while (!in_ready && waitCnt < 40) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput($sformatf("%s in_ready timeout", v.name), 0, 1);
      return;
    end
    codein    = v.code;
    en_flag   = v.en;
    fns_vec   = v.fns;
    in_valid  = 1'b1;
    out_ready = v.earlyReady;
    @(negedge clock);
    in_valid = 1'b0;
    if (v.scramble) begin
      codein  = 4'b1111;
      en_flag = 4'b1111;
      fns_vec = ~v.fns;
    end
    checkOutput($sformatf("%s in_ready busy", v.name), int'(in_ready), 0);
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput($sformatf("%s latency", v.name), lat, 4);
    checkOutput($sformatf("%s dataout", v.name), int'(dataout), v.expData);
    checkOutput($sformatf("%s dec_err", v.name), int'(dec_err), expErr);
    out_ready = 1'b0;
    for (int h = 0; h < v.holdCycles; h++) begin
      @(negedge clock);
      checkOutput($sformatf("%s hold valid", v.name), int'(out_valid), 1);
      checkOutput($sformatf("%s hold data", v.name), int'(dataout), v.expData);
      checkOutput($sformatf("%s hold in_ready", v.name), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput($sformatf("%s release valid", v.name), int'(out_valid), 0);
    checkOutput($sformatf("%s release in_ready", v.name), int'(in_ready), 1);
  endtask

  initial begin
    vec_t v;
    int   seen;
    int   sum;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    codein = '0; en_flag = '0; fns_vec = '0;

    table_q.push_back('{"basic",      4'b1010, 4'b1111, W_STD,  0, 0, 0, 4, 0});
    table_q.push_back('{"mask bit3",  4'b1111, 4'b0111, W_STD,  0, 1, 0, 4, 0});
    table_q.push_back('{"mask all",   4'b1111, 4'b0000, W_STD,  0, 0, 0, 0, 0});
    table_q.push_back('{"backpress",  4'b1010, 4'b1111, W_STD,  0, 0, 5, 4, 0});
    table_q.push_back('{"b2b",        4'b0001, 4'b1111, W_STD,  0, 0, 0, 1, 0});
    table_q.push_back('{"late change",4'b0100, 4'b1111, W_STD,  1, 0, 0, 2, 0});
    table_q.push_back('{"overflow",   4'b1111, 4'b1111, W_OVER, 0, 0, 1, 3, 1});

    repeat (2) @(negedge clock);
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset dataout", int'(dataout), 0);
    checkOutput("reset dec_err", int'(dec_err), 0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post-reset in_ready", int'(in_ready), 1);

    foreach (table_q[i]) applyStimulus(table_q[i]);

    // Reset while the accumulator is part way through a word.
    in_valid = 1'b1; codein = 4'b1111; en_flag = 4'b1111; fns_vec = W_STD;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset out_valid", int'(out_valid), 0);
    checkOutput("midreset in_ready low", int'(in_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset in_ready high", int'(in_ready), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (out_valid) seen = 1;
    end
    checkOutput("midreset stale word", seen, 0);
    applyStimulus('{"after midreset", 4'b1000, 4'b1111, W_STD, 0, 0, 0, 3, 0});

    // Reset coincident with in_valid must not accept the word.
    reset = 1'b1; in_valid = 1'b1; codein = 4'b1111;
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) seen = 1;
    end
    checkOutput("reset+valid ignored", seen, 0);
    checkOutput("reset+valid in_ready", int'(in_ready), 1);

    for (int r = 0; r < 40; r++) begin
      v.name       = $sformatf("rand%0d", r);
      v.code       = 4'($urandom);
      v.en         = 4'($urandom);
      v.fns        = 12'($urandom);
      v.scramble   = 1'($urandom);
      v.earlyReady = 1'($urandom);
      v.holdCycles = int'($urandom_range(0, 3));
      sum          = refSum(v.code, v.en, v.fns);
      v.expData    = sum % 8;
      v.expErrRaw  = (sum >= 8) ? 1 : 0;
      applyStimulus(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
